// File: rtl/vc_input_buffer.sv
// rtl/vc_input_buffer.sv - per-port virtual channel input buffer feeding a request/grant arbiter
// One FIFO and one downstream credit counter per VC; the granted VC pops into a registered output stage.
module vc_input_buffer #(
  parameter int NUM_VCS      = 4,
  parameter int BUF_DEPTH    = 4,
  parameter int FLIT_WIDTH   = 32,
  parameter int CREDIT_DEPTH = 4,
  localparam int VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [VCW-1:0]        in_vc,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_VCS-1:0]    credit_in,
  output logic [NUM_VCS-1:0]    requests,
  input  logic [NUM_VCS-1:0]    grants,
  output logic                  out_valid,
  output logic [VCW-1:0]        out_vc,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic [NUM_VCS-1:0]    credit_out,
  output logic                  overflow
);

  localparam int PW = $clog2(BUF_DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam int CW = $clog2(CREDIT_DEPTH + 1);

  logic [FLIT_WIDTH-1:0] mem [NUM_VCS][BUF_DEPTH];
  logic [PW-1:0]         wr_ptr [NUM_VCS];
  logic [PW-1:0]         rd_ptr [NUM_VCS];
  logic [CW-1:0]         credit_cnt [NUM_VCS];

  logic [NUM_VCS-1:0]    empty, full, wr_sel, serve;
  logic                  serve_any;
  logic [VCW-1:0]        serve_vc;
  logic [FLIT_WIDTH-1:0] head;

  always_comb begin
    empty    = '0;
    full     = '0;
    wr_sel   = '0;
    requests = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      empty[v]    = (wr_ptr[v] == rd_ptr[v]);
      full[v]     = (wr_ptr[v][PW-1] != rd_ptr[v][PW-1]) &&
                    (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
      wr_sel[v]   = in_valid && (in_vc == VCW'(v));
      requests[v] = !empty[v] && (credit_cnt[v] != '0);
    end
  end

  // Descending scan so the lowest-index requesting VC wins a multi-hot grant.
  always_comb begin
    serve_any = 1'b0;
    serve_vc  = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (grants[v] && requests[v]) begin
        serve_any = 1'b1;
        serve_vc  = VCW'(v);
      end
    end
    serve = serve_any ? (NUM_VCS'(1) << serve_vc) : '0;
    head  = mem[serve_vc][rd_ptr[serve_vc][AW-1:0]];
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VCS; v++) begin
      if (wr_sel[v] && !full[v]) mem[v][wr_ptr[v][AW-1:0]] <= in_flit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        wr_ptr[v]     <= '0;
        rd_ptr[v]     <= '0;
        credit_cnt[v] <= CW'(CREDIT_DEPTH);
      end
      out_valid  <= 1'b0;
      out_vc     <= '0;
      out_flit   <= '0;
      credit_out <= '0;
      overflow   <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        // full is the registered view, so a same-cycle pop does not make room.
        if (wr_sel[v] && !full[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
        if (wr_sel[v] && full[v])  overflow  <= 1'b1;
        if (serve[v])              rd_ptr[v] <= rd_ptr[v] + PW'(1);
        case ({serve[v], credit_in[v]})
          2'b10:   credit_cnt[v] <= credit_cnt[v] - CW'(1);
          2'b01:   if (credit_cnt[v] != CW'(CREDIT_DEPTH)) credit_cnt[v] <= credit_cnt[v] + CW'(1);
          default: credit_cnt[v] <= credit_cnt[v];
        endcase
      end
      out_valid  <= serve_any;
      credit_out <= serve;
      if (serve_any) begin
        out_vc   <= serve_vc;
        out_flit <= head;
      end
    end
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// tb/tb_vc_input_buffer.sv - directed self-checking bench for vc_input_buffer
module tb_vc_input_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_vc;
  logic [31:0] in_flit;
  logic [3:0]  credit_in;
  logic [3:0]  requests;
  logic [3:0]  grants;
  logic        out_valid;
  logic [1:0]  out_vc;
  logic [31:0] out_flit;
  logic [3:0]  credit_out;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  vc_input_buffer #(.NUM_VCS(4), .BUF_DEPTH(4), .FLIT_WIDTH(32), .CREDIT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
    .credit_in(credit_in), .requests(requests), .grants(grants), .out_valid(out_valid),
    .out_vc(out_vc), .out_flit(out_flit), .credit_out(credit_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_vc = 0; in_flit = 0; credit_in = 0; grants = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic write_flit(input logic [1:0] vc, input logic [31:0] f);
    in_valid = 1; in_vc = vc; in_flit = f;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (requests !== 4'b0000) begin bad++; $display("FAIL reset_requests got=%b want=0000", requests); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_vc !== 2'd0) begin bad++; $display("FAIL reset_out_vc got=%0d want=0", out_vc); end
    total++; if (out_flit !== 32'h0) begin bad++; $display("FAIL reset_out_flit got=%h want=0", out_flit); end
    total++; if (credit_out !== 4'b0000) begin bad++; $display("FAIL reset_credit_out got=%b want=0000", credit_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_single();
    do_reset();
    write_flit(2'd2, 32'hA5A5_0001);
    total++; if (requests !== 4'b0100) begin bad++; $display("FAIL single_req got=%b want=0100", requests); end
    grants = 4'b0100;
    tick();
    grants = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", out_valid); end
    total++; if (out_vc !== 2'd2) begin bad++; $display("FAIL single_vc got=%0d want=2", out_vc); end
    total++; if (out_flit !== 32'hA5A5_0001) begin bad++; $display("FAIL single_flit got=%h want=a5a50001", out_flit); end
    total++; if (credit_out !== 4'b0100) begin bad++; $display("FAIL single_credit got=%b want=0100", credit_out); end
    total++; if (requests !== 4'b0000) begin bad++; $display("FAIL single_req_after got=%b want=0000", requests); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b want=0", out_valid); end
    total++; if (credit_out !== 4'b0000) begin bad++; $display("FAIL single_idle_credit got=%b want=0000", credit_out); end
    total++; if (out_flit !== 32'hA5A5_0001) begin bad++; $display("FAIL single_hold_flit got=%h want=a5a50001", out_flit); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      write_flit(2'd0, 32'(i));
      if (i == 3) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
      end
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      grants = 4'b0001;
      tick();
      total++;
      if (out_valid !== 1'b1 || out_flit !== 32'(i)) begin
        bad++; $display("FAIL ovf_drain%0d got valid=%b flit=%h want valid=1 flit=%h", i, out_valid, out_flit, 32'(i));
      end
    end
    grants = 0;
    total++; if (requests !== 4'b0000) begin bad++; $display("FAIL ovf_empty got=%b want=0000", requests); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
  endtask

  task automatic test_credit_exhaust();
    int pops;
    do_reset();
    credit_in = 4'b0010;
    tick();
    tick();
    credit_in = 0;
    pops = 0;
    grants = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) begin in_valid = 1; in_vc = 2'd1; in_flit = 32'h100 + 32'(c); end
      else in_valid = 0;
      tick();
      if (out_valid) begin
        total++;
        if (out_flit !== 32'h100 + 32'(pops)) begin
          bad++; $display("FAIL cred_order got=%h want=%h", out_flit, 32'h100 + 32'(pops));
        end
        pops++;
      end
    end
    in_valid = 0;
    grants = 0;
    total++; if (pops != 4) begin bad++; $display("FAIL cred_pops got=%0d want=4", pops); end
    total++; if (requests !== 4'b0000) begin bad++; $display("FAIL cred_stall got=%b want=0000", requests); end
    credit_in = 4'b0010;
    tick();
    credit_in = 0;
    total++; if (requests !== 4'b0010) begin bad++; $display("FAIL cred_return got=%b want=0010", requests); end
    grants = 4'b0010;
    tick();
    grants = 0;
    total++; if (out_valid !== 1'b1 || out_flit !== 32'h104) begin
      bad++; $display("FAIL cred_extra_pop got valid=%b flit=%h want valid=1 flit=00000104", out_valid, out_flit);
    end
    total++; if (requests !== 4'b0000) begin bad++; $display("FAIL cred_stall2 got=%b want=0000", requests); end
  endtask

  task automatic test_pop_credit();
    do_reset();
    for (int i = 0; i < 4; i++) write_flit(2'd3, 32'h300 + 32'(i));
    grants = 4'b1000;
    credit_in = 4'b1000;
    tick();
    credit_in = 0;
    total++; if (out_valid !== 1'b1 || out_vc !== 2'd3) begin
      bad++; $display("FAIL popcred_pop got valid=%b vc=%0d want valid=1 vc=3", out_valid, out_vc);
    end
    for (int i = 0; i < 3; i++) tick();
    grants = 0;
    write_flit(2'd3, 32'h310);
    write_flit(2'd3, 32'h311);
    total++; if (requests !== 4'b1000) begin bad++; $display("FAIL popcred_req got=%b want=1000", requests); end
    grants = 4'b1000;
    tick();
    grants = 0;
    total++; if (out_flit !== 32'h310) begin bad++; $display("FAIL popcred_flit got=%h want=00000310", out_flit); end
    total++; if (requests !== 4'b0000) begin bad++; $display("FAIL popcred_stall got=%b want=0000", requests); end
  endtask

  task automatic test_grant_edge();
    do_reset();
    write_flit(2'd1, 32'h11);
    write_flit(2'd3, 32'h33);
    grants = 4'b1111;
    tick();
    total++; if (out_vc !== 2'd1 || out_flit !== 32'h11 || credit_out !== 4'b0010) begin
      bad++; $display("FAIL multihot got vc=%0d flit=%h credit=%b want vc=1 flit=00000011 credit=0010", out_vc, out_flit, credit_out);
    end
    grants = 4'b0001;
    tick();
    total++; if (out_valid !== 1'b0 || credit_out !== 4'b0000 || out_vc !== 2'd1) begin
      bad++; $display("FAIL idle_grant got valid=%b credit=%b vc=%0d want valid=0 credit=0000 vc=1", out_valid, credit_out, out_vc);
    end
    grants = 0;
    total++; if (requests !== 4'b1000) begin bad++; $display("FAIL idle_grant_req got=%b want=1000", requests); end
  endtask

  task automatic test_round_robin();
    int ptr, seen, idx;
    logic found;
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int v = 0; v < 4; v++) write_flit(2'(v), 32'h400 + 32'(v * 16 + n));
    ptr = 0; seen = 0;
    for (int c = 0; c < 30 && seen < 8; c++) begin
      grants = 0; found = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (ptr + k) % 4;
        if (!found && requests[idx]) begin
          grants[idx] = 1'b1; found = 1; ptr = (idx + 1) % 4;
        end
      end
      tick();
      if (out_valid) begin
        total++;
        if (out_vc !== 2'(seen % 4)) begin bad++; $display("FAIL rr_seq%0d got=%0d want=%0d", seen, out_vc, seen % 4); end
        seen++;
      end
    end
    grants = 0;
    total++; if (seen != 8) begin bad++; $display("FAIL rr_count got=%0d want=8", seen); end
  endtask

  task automatic test_reset_mid();
    int pops;
    do_reset();
    for (int n = 0; n < 2; n++)
      for (int v = 0; v < 4; v++) write_flit(2'(v), 32'h500 + 32'(v * 16 + n));
    grants = 4'b0100;
    tick();
    grants = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", out_valid); end
    reset = 0;
    #1;
    total++; if (out_valid !== 1'b0 || out_vc !== 2'd0 || out_flit !== 32'h0 || credit_out !== 4'b0000 || requests !== 4'b0000) begin
      bad++; $display("FAIL mid_async got valid=%b vc=%0d flit=%h credit=%b req=%b want all zero", out_valid, out_vc, out_flit, credit_out, requests);
    end
    tick();
    reset = 1;
    tick();
    total++; if (requests !== 4'b0000) begin bad++; $display("FAIL mid_after_req got=%b want=0000", requests); end
    for (int i = 0; i < 4; i++) write_flit(2'd2, 32'h600 + 32'(i));
    pops = 0;
    grants = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) pops++;
    end
    grants = 0;
    total++; if (pops != 4) begin bad++; $display("FAIL mid_credits got pops=%0d want=4", pops); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_credit_exhaust();
    test_pop_credit();
    test_grant_edge();
    test_round_robin();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
